srt_div_ctrl: RTL and testbench
===============================

# srt_div_ctrl

Sequencing controller for the radix-4 SRT mantissa divider. It runs the load / iterate / convert / deliver sequence with a start/done handshake. It gates the quotient-digit memory and partial-remainder register enables, and forwards the selected quotient digit (-3..+3) as the one-hot digit select consumed by the digit memory and the divisor-multiple mux. It also flags divide-by-zero and malformed digit selections.

## Interface
- ITERS, 27, number of quotient digits (iteration cycles) per division; legal range 2..63
- CW, 6, iteration counter width; must satisfy 2^CW > ITERS
- clk  in  1  system clock, all flops rising-edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  request a division; sampled only in IDLE
- divisor_zero  in  1  divisor mantissa is zero; sampled in LOAD
- abort  in  1  cancel current operation
- dig_sel  in  7  one-hot digit from selection logic; bit i = digit (i-3), so bit 3 = digit 0
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE
- ld_op  out  1  latch operands into divider registers
- pr_en  out  1  partial-remainder register enable
- qi_en  out  1  quotient-digit memory enable
- mul_sel  out  7  one-hot digit forwarded to digit memory / multiple mux; bit order as dig_sel
- conv_en  out  1  redundant-to-binary quotient conversion enable
- iter_cnt  out  CW  completed iterations of the current division
- done  out  1  result valid
- dz_flag  out  1  divide-by-zero result; valid while done
- sel_err  out  1  sticky: a non-one-hot dig_sel was seen in this division; valid while done

## Operation
- States: IDLE, LOAD, ITER, CONV, DONE.
- IDLE: all outputs 0 except mul_sel = 7'b0001000. start=1 moves to LOAD and clears sel_err and dz_flag.
- LOAD (1 cycle): ld_op=1 and iter_cnt=0.
  - divisor_zero=1: set dz_flag and go to DONE.
  - Otherwise go to ITER.
- ITER: pr_en=1, qi_en=1, mul_sel=dig_sel.
  - If dig_sel is not exactly one-hot (zero or multiple bits set), mul_sel is forced to 7'b0001000 (digit 0) and sel_err is set.
  - iter_cnt increments every ITER cycle. At iter_cnt==ITERS-1 go to CONV.
- CONV (1 cycle): conv_en=1. Go to DONE.
- DONE: done=1. iter_cnt, dz_flag and sel_err are held.
  - out_ready=1 returns to IDLE on the next edge.
  - start is ignored in DONE and in every other non-IDLE state.
- abort=1 in any non-IDLE state forces IDLE on the next edge. done is not produced and flags are left stale.
  - Abort has priority over every transition, including DONE handshake completion.
- mul_sel is 7'b0001000 in every state other than ITER.

## Timing
- Reset: state IDLE. busy, ld_op, pr_en, qi_en, conv_en, done, dz_flag, sel_err = 0. iter_cnt = 0. mul_sel = 7'b0001000.
- All outputs are registered-state decodes. mul_sel is combinational from dig_sel while in ITER (same-cycle digit forwarding).
- Cycle numbering, with start sampled high at edge k:
  - LOAD occupies cycle k+1.
  - ITER occupies cycles k+2 .. k+ITERS+1.
  - CONV occupies cycle k+ITERS+2.
  - done rises after edge k+ITERS+3.
- Start-to-done latency is ITERS+3 edges (30 at the default).
- Divide-by-zero path: done rises after edge k+2.
- start and out_ready both high in DONE: return to IDLE only. A new division needs start sampled in IDLE, so back-to-back operations have a minimum of one IDLE cycle between them.
- Reset asserted mid-operation: immediate return to reset values, asynchronously.

## Structure
- Package srt_div_pkg holds:
  - the state enum;
  - digit index constants DIG_N3..DIG_P3 = 0..6;
  - the constant DIG_ZERO_ONEHOT = 7'b0001000;
  - the default ITERS value.
- One sub-module, srt_iter_counter: CW-bit counter with clear, enable and a terminal flag at ITERS-1.

## Test plan
- Normal run (ITERS=27): pulse start, dig_sel cycling through all seven one-hot values, out_ready=1 -> ld_op for 1 cycle, qi_en/pr_en for exactly 27 cycles, mul_sel equal to dig_sel in each of them, conv_en for 1 cycle, done after 30 edges, iter_cnt=27 at done, flags 0.
- Divide-by-zero: start with divisor_zero=1 -> no qi_en cycles, done 2 edges after start, dz_flag=1, iter_cnt=0.
- Bad digit: dig_sel=7'b0011000 in iteration 5 -> mul_sel=7'b0001000 that cycle, sel_err=1 at done, run length unchanged.
- Backpressure: out_ready=0 for 10 cycles in DONE -> done and flags held stable. Raise out_ready -> IDLE next edge. start held high throughout -> no second division until IDLE has been reached.
- Abort in ITER at iter_cnt=12 -> IDLE next edge, qi_en=0, done never asserts. A fresh start then completes normally in 30 edges.
- n_rst asserted in CONV -> all outputs at reset values without waiting for a clock edge, mul_sel=7'b0001000.

Source files
------------

// File: rtl/srt_div_ctrl_pkg.sv
// srt_div_pkg: shared types and constants for the radix-4 SRT divider controller.
//   state_e          controller state encoding
//   DIG_N3..DIG_P3   bit index of each quotient digit (-3..+3) in one-hot digit vectors
//   DIG_ZERO_ONEHOT  one-hot encoding of digit 0, the idle/safe multiple select
//   ITERS_DEFAULT    default quotient digits per division
package srt_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CONV,
    S_DONE
  } state_e;

  localparam int DIG_N3 = 0;
  localparam int DIG_N2 = 1;
  localparam int DIG_N1 = 2;
  localparam int DIG_0  = 3;
  localparam int DIG_P1 = 4;
  localparam int DIG_P2 = 5;
  localparam int DIG_P3 = 6;
  localparam int DIG_W  = DIG_P3 - DIG_N3 + 1;

  localparam logic [DIG_W-1:0] DIG_ZERO_ONEHOT = DIG_W'(1 << DIG_0);

  localparam int ITERS_DEFAULT = 27;

  // Exactly one bit set; zero and multi-hot both fail.
  function automatic logic is_onehot(input logic [DIG_W-1:0] v);
    return (v != '0) && ((v & (v - DIG_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/srt_div_ctrl_if.sv
// srt_div_ctrl_if: handshake / control bundle between the divider controller and its
// environment.
//   slave  : controller view (start, divisor_zero, abort, dig_sel, out_ready in;
//            busy, ld_op, pr_en, qi_en, mul_sel, conv_en, iter_cnt, done, dz_flag, sel_err out)
//   master : environment view (directions mirrored)
interface srt_div_ctrl_if #(
  parameter int CW = 6
);
  logic          start;
  logic          divisor_zero;
  logic          abort;
  logic [6:0]    dig_sel;
  logic          out_ready;

  logic          busy;
  logic          ld_op;
  logic          pr_en;
  logic          qi_en;
  logic [6:0]    mul_sel;
  logic          conv_en;
  logic [CW-1:0] iter_cnt;
  logic          done;
  logic          dz_flag;
  logic          sel_err;

  modport slave (
    input  start, divisor_zero, abort, dig_sel, out_ready,
    output busy, ld_op, pr_en, qi_en, mul_sel, conv_en, iter_cnt, done, dz_flag, sel_err
  );

  modport master (
    output start, divisor_zero, abort, dig_sel, out_ready,
    input  busy, ld_op, pr_en, qi_en, mul_sel, conv_en, iter_cnt, done, dz_flag, sel_err
  );
endinterface

// File: rtl/srt_iter_counter.sv
// srt_iter_counter: iteration counter for the SRT divider.
//   clk, n_rst : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count up by one
//   cnt        : completed iterations
//   term       : cnt is at ITERS-1, i.e. the current iteration is the last one
module srt_iter_counter #(
  parameter int CW    = 6,
  parameter int ITERS = 27
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          term
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign term = (cnt == CW'(ITERS - 1));

endmodule

// File: rtl/srt_div_ctrl.sv
// srt_div_ctrl: sequencing controller for the radix-4 SRT mantissa divider.
// Runs LOAD -> ITER x ITERS -> CONV -> DONE with a start/done handshake; a zero
// divisor short-cuts LOAD -> DONE. abort returns to IDLE from any busy state.
//   clk, n_rst : clock, async active-low reset
//   bus        : srt_div_ctrl_if.slave (see interface for signal list)
// Control strobes are flops loaded from the next-state value, so they line up
// exactly with the state they decode. mul_sel is the one combinational output:
// the selected digit is forwarded in the same cycle it is produced.
module srt_div_ctrl
  import srt_div_pkg::*;
#(
  parameter int ITERS = ITERS_DEFAULT,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          n_rst,
  srt_div_ctrl_if.slave bus
);

  state_e        state, nxt;
  logic          dz_r, se_r;
  logic          busy_r, ld_r, iter_r, conv_r, done_r;
  logic [CW-1:0] cnt;
  logic          term;
  logic          dig_ok;

  assign dig_ok = is_onehot(bus.dig_sel);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) nxt = S_LOAD;
      S_LOAD:  nxt = bus.divisor_zero ? S_DONE : S_ITER;
      S_ITER:  if (term) nxt = S_CONV;
      S_CONV:  nxt = S_DONE;
      S_DONE:  if (bus.out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // Abort overrides every other transition, including the DONE handshake.
    if (state != S_IDLE && bus.abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      ld_r   <= 1'b0;
      iter_r <= 1'b0;
      conv_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      se_r   <= 1'b0;
    end else begin
      state  <= nxt;
      busy_r <= (nxt != S_IDLE);
      ld_r   <= (nxt == S_LOAD);
      iter_r <= (nxt == S_ITER);
      conv_r <= (nxt == S_CONV);
      done_r <= (nxt == S_DONE);
      if (state == S_IDLE && bus.start) begin
        dz_r <= 1'b0;
        se_r <= 1'b0;
      end
      if (state == S_LOAD && bus.divisor_zero && !bus.abort) dz_r <= 1'b1;
      if (state == S_ITER && !dig_ok) se_r <= 1'b1;
    end
  end

  // Counter reads 0 in IDLE and LOAD, counts every ITER cycle and then holds
  // through CONV/DONE so the completed count is visible alongside done.
  srt_iter_counter #(.CW(CW), .ITERS(ITERS)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   ((nxt == S_IDLE) || (nxt == S_LOAD)),
    .en    (state == S_ITER),
    .cnt   (cnt),
    .term  (term)
  );

  assign bus.busy     = busy_r;
  assign bus.ld_op    = ld_r;
  assign bus.pr_en    = iter_r;
  assign bus.qi_en    = iter_r;
  assign bus.conv_en  = conv_r;
  assign bus.done     = done_r;
  assign bus.iter_cnt = cnt;
  // Flags may be left stale by an abort; masking with busy keeps IDLE clean.
  assign bus.dz_flag  = dz_r & busy_r;
  assign bus.sel_err  = se_r & busy_r;
  // Malformed selections degrade to digit 0 so the multiple mux never sees
  // a multi-hot or empty select.
  assign bus.mul_sel  = (state == S_ITER && dig_ok) ? bus.dig_sel : DIG_ZERO_ONEHOT;

endmodule

// File: tb/tb_srt_div_ctrl.sv
module tb_srt_div_ctrl;
  import srt_div_pkg::*;

  localparam int ITERS = 27;
  localparam int CW    = 6;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  srt_div_ctrl_if #(.CW(CW)) bus ();

  srt_div_ctrl #(.ITERS(ITERS), .CW(CW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic          dz;
    logic          se;
    logic [CW-1:0] cnt;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, " ctl"}, {bus.busy, bus.ld_op, bus.pr_en, bus.qi_en, bus.conv_en,
                        bus.done, bus.dz_flag, bus.sel_err}, 32'h0);
    chk({pfx, " iter_cnt"}, bus.iter_cnt, 32'h0);
    chk({pfx, " mul_sel"}, bus.mul_sel, 32'h08);
  endtask

  // One division: dz selects divide-by-zero, bad_iter (>=0) injects a two-hot
  // digit at that iteration, hold = DONE cycles with out_ready low, keep_start
  // leaves start high until IDLE is reached again.
  task automatic do_div(input bit dz, input int bad_iter, input int hold, input bit keep_start);
    exp_t e, g;
    int edges, n_ld, n_it, n_pr, n_cv;
    e.dz  = dz;
    e.se  = (bad_iter >= 0) && !dz;
    e.cnt = dz ? CW'(0) : CW'(ITERS);
    e.lat = dz ? 2 : ITERS + 3;
    sb.push_back(e);
    n_ld = 0; n_it = 0; n_pr = 0; n_cv = 0;

    @(negedge clk);
    bus.start = 1'b1; bus.divisor_zero = dz; bus.out_ready = 1'b0;
    @(posedge clk); edges = 1; #1;
    if (!keep_start) bus.start = 1'b0;
    while (!bus.done && edges < 200) begin
      if (bus.ld_op)   n_ld++;
      if (bus.conv_en) n_cv++;
      if (bus.pr_en)   n_pr++;
      if (bus.qi_en) begin
        logic [6:0] d, em;
        d  = (n_it == bad_iter) ? 7'b0011000 : 7'(1 << (n_it % 7));
        em = (n_it == bad_iter) ? 7'b0001000 : d;
        bus.dig_sel = d;
        #1;
        chk($sformatf("mul_sel it%0d", n_it), bus.mul_sel, em);
        n_it++;
      end
      @(posedge clk); edges++; #1;
    end
    bus.dig_sel = DIG_ZERO_ONEHOT;
    bus.divisor_zero = 1'b0;

    chk("done seen", bus.done, 1'b1);
    g = sb.pop_front();
    chk("latency", edges, g.lat);
    chk("ld_op cycles", n_ld, 1);
    chk("qi_en cycles", n_it, g.cnt);
    chk("pr_en cycles", n_pr, g.cnt);
    chk("conv_en cycles", n_cv, g.dz ? 0 : 1);
    chk("iter_cnt@done", bus.iter_cnt, g.cnt);
    chk("dz_flag@done", bus.dz_flag, g.dz);
    chk("sel_err@done", bus.sel_err, g.se);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d", i), {bus.done, bus.ld_op, bus.busy, bus.dz_flag, bus.sel_err, bus.iter_cnt},
          {1'b1, 1'b0, 1'b1, g.dz, g.se, g.cnt});
    end

    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    if (keep_start) bus.start = 1'b0;
    bus.out_ready = 1'b0;
    chk("idle after ready", {bus.busy, bus.done, bus.ld_op}, 3'b000);
    chk("iter_cnt idle", bus.iter_cnt, 0);
    chk("mul_sel idle", bus.mul_sel, 7'b0001000);
  endtask

  initial begin
    int n;
    bit seen_done;
    n_rst = 1'b0;
    bus.start = 1'b0; bus.divisor_zero = 1'b0; bus.abort = 1'b0;
    bus.dig_sel = DIG_ZERO_ONEHOT; bus.out_ready = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("idle");

    do_div(1'b0, -1, 0, 1'b0);   // normal
    do_div(1'b1, -1, 0, 1'b0);   // divide by zero
    do_div(1'b0,  5, 0, 1'b0);   // malformed digit
    do_div(1'b0, -1, 10, 1'b1);  // backpressure, start held

    // Abort in ITER at iter_cnt == 12
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    n = 0;
    while (!(bus.qi_en && bus.iter_cnt == 12) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("reach iter 12", {bus.qi_en, bus.iter_cnt}, {1'b1, CW'(12)});
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort idle", {bus.busy, bus.qi_en, bus.pr_en}, 3'b000);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("no done after abort", seen_done, 1'b0);
    do_div(1'b0, -1, 0, 1'b0);   // fresh run after abort

    // Reset asserted during CONV
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    n = 0;
    while (!bus.conv_en && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("reach conv", bus.conv_en, 1'b1);
    n_rst = 1'b0;
    #1;
    chk_reset_vals("async reset");
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("post reset");

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
